// File: rtl/dram_pkg.sv
// Shared sizing defaults for the two-bank word-addressed RAM.
package dram_pkg;
    localparam int DRAM_ADDR_W = 15;
    localparam int DRAM_DATA_W = 8;
endpackage

// File: rtl/dram_bank.sv
// One bank of single-port synchronous RAM with read-old-data and a resettable
// read register; the array itself has no reset so it stays block-RAM friendly.
module dram_bank
    import dram_pkg::*;
#(
    parameter int ADDR_W = DRAM_ADDR_W - 1,
    parameter int DATA_W = DRAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    localparam int DEPTH = 2 ** ADDR_W;

    // Power-up contents are all zero; reset never touches the array.
    logic [DATA_W-1:0] mem_r [DEPTH] = '{default: '0};

    // Array write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= din;
        end
    end

    // Read register: samples the pre-write contents on the same edge as a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout <= '0;
        end else begin
            dout <= mem_r[addr];
        end
    end
endmodule

// File: rtl/dram.sv
// Word-addressed RAM built from two banks split on the address MSB; one cycle
// of read latency, read-old-data on writes, dout forced to zero during reset.
module dram
    import dram_pkg::*;
#(
    parameter int ADDR_W = DRAM_ADDR_W,
    parameter int DATA_W = DRAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    localparam int BANK_AW = ADDR_W - 1;

    logic              bank_sel_s;
    logic              bank_sel_r;
    logic [1:0]        bank_we_s;
    logic [DATA_W-1:0] bank_dout_s [2];

    assign bank_sel_s = addr[ADDR_W-1];

    // Steer the write strobe to the addressed bank; no writes while in reset.
    always_comb begin
        bank_we_s = 2'b00;
        if (we && !reset) begin
            bank_we_s[bank_sel_s] = 1'b1;
        end else begin
            bank_we_s = 2'b00;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        dram_bank #(
            .ADDR_W(BANK_AW),
            .DATA_W(DATA_W)
        ) u_bank (
            .clk  (clk),
            .reset(reset),
            .we   (bank_we_s[b]),
            .addr (addr[BANK_AW-1:0]),
            .din  (din),
            .dout (bank_dout_s[b])
        );
    end

    // Bank select travels with the read so the mux matches last cycle's address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_sel_r <= 1'b0;
        end else begin
            bank_sel_r <= bank_sel_s;
        end
    end

    // Output mux driven only by registers; both bank read registers are zero in reset.
    always_comb begin
        dout = '0;
        if (bank_sel_r) begin
            dout = bank_dout_s[1];
        end else begin
            dout = bank_dout_s[0];
        end
    end
endmodule

// File: tb/tb_dram.sv
// Scoreboard bench for dram: the driver predicts each edge's dout from a sparse
// reference memory; a clock-tied monitor pops and compares every cycle.
module tb_dram;
    localparam int AW = 15;
    localparam int DW = 8;

    typedef struct {
        logic [DW-1:0] exp;
        string         tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;

    int            total = 0;
    int            bad = 0;
    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem [int];

    dram #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk  (clk),
        .reset(reset),
        .we   (we),
        .addr (addr),
        .din  (din),
        .dout (dout)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return 8'h00;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Predict the value the next edge will present, then apply the write to the model.
    task automatic predict(input string tag);
        exp_t e;
        e.tag = tag;
        if (reset) begin
            e.exp = 8'h00;
        end else begin
            e.exp = ref_rd(addr);
            if (we) ref_mem[int'(addr)] = din;
        end
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
        @(negedge clk);
        we = w;
        addr = a;
        din = d;
        predict(tag);
    endtask

    // Monitor: compare just after each edge, then again late in the cycle for hold.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.tag, dout, e.exp);
                #7;
                if (!reset) check({e.tag, "_hold"}, dout, e.exp);
            end
        end
    end

    initial begin
        logic [AW-1:0] ra;
        int            waited;

        #1 reset = 1'b1;
        #1 check("por_reset", dout, 8'h00);
        @(posedge clk);
        #3 reset = 1'b0;

        cycle(1'b0, 15'h6ABC, 8'h00, "unwritten");

        cycle(1'b1, 15'h0000, 8'hA5, "wr_lo");
        cycle(1'b1, 15'h7FFF, 8'h3C, "wr_hi");
        cycle(1'b0, 15'h0000, 8'h00, "rd_lo");
        cycle(1'b0, 15'h7FFF, 8'h00, "rd_hi");

        cycle(1'b1, 15'h1234, 8'h11, "wr_first");
        cycle(1'b1, 15'h1234, 8'h22, "rd_old");
        cycle(1'b0, 15'h1234, 8'h00, "rd_new");

        cycle(1'b1, 15'h0010, 8'h01, "wr_b0");
        cycle(1'b1, 15'h4010, 8'h02, "wr_b1");
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, (i % 2 == 0) ? 15'h0010 : 15'h4010, 8'h00, "alt");
        end

        // Reset asserted while a write to 15'h2000 is pending must block it.
        cycle(1'b1, 15'h2000, 8'h5A, "wr_keep");
        cycle(1'b0, 15'h2000, 8'h00, "rd_keep");
        @(negedge clk);
        we = 1'b1;
        addr = 15'h2000;
        din = 8'hFF;
        #2 reset = 1'b1;
        #1 check("reset_async", dout, 8'h00);
        predict("in_reset");
        cycle(1'b1, 15'h2000, 8'hFF, "in_reset");
        cycle(1'b1, 15'h2000, 8'hFF, "in_reset");
        @(posedge clk);
        #3 reset = 1'b0;
        #1 check("post_release", dout, 8'h00);
        cycle(1'b0, 15'h2000, 8'h00, "survive");

        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                ra = {1'($urandom_range(0, 1)), 10'h000, 4'($urandom_range(0, 15))};
            end else begin
                ra = 15'($urandom);
            end
            cycle(1'($urandom_range(0, 1)), ra, 8'($urandom), "random");
        end

        @(negedge clk);
        we = 1'b0;
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dram.md
DRAM -- requirements
Module: dram

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, word-address width (32768 words).
REQ-002 SHALL have parameter DATA_W, default 8, word width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port we  input  1  write enable, sampled on rising clk.
REQ-006 SHALL have port addr  input  ADDR_W  word address for both read and write.
REQ-007 SHALL have port din  input  DATA_W  write data.
REQ-008 SHALL have port dout  output  DATA_W  registered read data.

Function
REQ-009 SHALL implement a single-port synchronous RAM of 2^ADDR_W words x DATA_W bits, fully addressable, no holes or aliasing.
REQ-010 SHALL register dout on every rising clk (no read enable): dout = mem[addr] as sampled at that edge, i.e. exactly one cycle of read latency.
REQ-011 SHALL write din to mem[addr] on a rising clk when we=1 and reset=0.
REQ-012 SHALL use read-old-data semantics: when we=1 at an edge, dout takes the contents of mem[addr] from before that write.
REQ-013 SHALL update dout on every cycle regardless of we; address may change every cycle (caller time-multiplexes CPU and video addresses on alternate cycles).
REQ-014 SHALL hold dout unchanged between edges; no combinational path from addr/din/we to dout.
REQ-015 SHALL treat addresses 0 and 2^ADDR_W-1 identically to any other; no wrap or overflow logic.
REQ-016 SHALL initialise all array words to 0 at power-up (simulation and FPGA init).

Reset
REQ-017 SHALL force dout to 0 asynchronously while reset=1, and keep it 0 until the first rising clk after reset deasserts.
REQ-018 SHALL ignore we while reset=1 (no array write).
REQ-019 SHALL NOT clear array contents on reset; data written before reset survives it.
REQ-020 SHALL produce, on the first edge after reset release, dout = mem[addr] normally.

Structure
REQ-021 SHALL split the array into two banks of 2^(ADDR_W-1) words each, selected by addr[ADDR_W-1], via one sub-module dram_bank (single-port synchronous RAM with read-old-data, inferable as block RAM).
REQ-022 SHALL register the bank-select bit alongside the read so the output mux selects the bank addressed in the previous cycle; total latency stays one cycle.
REQ-023 SHALL place ADDR_W and DATA_W defaults in the shared package dram_pkg; no typedefs are required.

Verification
REQ-024 Write 8'hA5 to 15'h0000, then 8'h3C to 15'h7FFF, then read each -> dout=8'hA5 and 8'h3C, each one cycle after its address is applied.
REQ-025 Write 8'h11 to 15'h1234, then in the next cycle write 8'h22 to the same address with we=1 -> dout shows 8'h11 on that edge, 8'h22 on a following read.
REQ-026 Alternate addr every cycle between 15'h0010 (holding 8'h01) and 15'h4010 (holding 8'h02) -> dout alternates 8'h01/8'h02, lagging addr by exactly one cycle; confirms no bank aliasing.
REQ-027 Write 8'h5A to 15'h2000, assert reset mid-cycle with we=1, din=8'hFF, addr=15'h2000 -> dout goes 0 immediately; after release, reading 15'h2000 returns 8'h5A.
REQ-028 Read an unwritten address 15'h6ABC after power-up -> dout=8'h00.
REQ-029 Random writes/reads over 10k cycles checked against a reference array model -> zero mismatches.
